// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the timing generator slice.
package vga_timing_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative sync polarity
  localparam int unsigned VGA640_H_DISPLAY   = 640;
  localparam int unsigned VGA640_H_FPORCH    = 16;
  localparam int unsigned VGA640_H_SYNCPULSE = 96;
  localparam int unsigned VGA640_H_BPORCH    = 48;
  localparam int unsigned VGA640_V_DISPLAY   = 480;
  localparam int unsigned VGA640_V_FPORCH    = 10;
  localparam int unsigned VGA640_V_SYNCPULSE = 2;
  localparam int unsigned VGA640_V_BPORCH    = 33;
  localparam bit          VGA640_HSYNC_POL   = 1'b0;
  localparam bit          VGA640_VSYNC_POL   = 1'b0;

  // 800x600 @ 60 Hz (40 MHz pixel clock), positive sync polarity
  localparam int unsigned SVGA800_H_DISPLAY   = 800;
  localparam int unsigned SVGA800_H_FPORCH    = 40;
  localparam int unsigned SVGA800_H_SYNCPULSE = 128;
  localparam int unsigned SVGA800_H_BPORCH    = 88;
  localparam int unsigned SVGA800_V_DISPLAY   = 600;
  localparam int unsigned SVGA800_V_FPORCH    = 1;
  localparam int unsigned SVGA800_V_SYNCPULSE = 4;
  localparam int unsigned SVGA800_V_BPORCH    = 23;
  localparam bit          SVGA800_HSYNC_POL   = 1'b1;
  localparam bit          SVGA800_VSYNC_POL   = 1'b1;

  // Minimum counter width able to hold max(h_total, v_total) - 1.
  function automatic int unsigned calc_cw(input int unsigned h_total,
                                          input int unsigned v_total);
    int unsigned max_cnt;
    max_cnt = ((h_total > v_total) ? h_total : v_total) - 1;
    for (int unsigned w = 1; w < 32; w++) begin
      if ((32'd1 << w) > max_cnt) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counter plus region flags registered from the next count.
module vga_axis_counter #(
  parameter int unsigned DISP = 640,
  parameter int unsigned FP   = 16,
  parameter int unsigned SP   = 96,
  parameter int unsigned BP   = 48,
  parameter int unsigned CW   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output logic          active,
  output logic          sync_on,
  output logic          wrap
);

  localparam int unsigned TOTAL = DISP + FP + SP + BP;

  if (DISP < 1 || FP < 1 || SP < 1 || BP < 1) begin : g_chk_regions
    $fatal(1, "vga_axis_counter: every region length must be >= 1");
  end
  if (((TOTAL - 1) >> CW) != 0) begin : g_chk_width
    $fatal(1, "vga_axis_counter: CW too small for TOTAL-1");
  end

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] DISP_END   = CW'(DISP);
  localparam logic [CW-1:0] SYNC_START = CW'(DISP + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(DISP + FP + SP);

  logic [CW-1:0] cnt_next;

  assign wrap = (cnt == LAST);

  always_comb begin
    cnt_next = wrap ? '0 : cnt + 1'b1;
  end

  // Flags decode cnt_next so they line up with cnt, with no added latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= LAST;
      active  <= 1'b0;
      sync_on <= 1'b0;
    end else if (adv) begin
      cnt     <= cnt_next;
      active  <= (cnt_next < DISP_END);
      sync_on <= (cnt_next >= SYNC_START) && (cnt_next < SYNC_END);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: two chained axis counters, polarity, x/y gating, strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = VGA640_H_DISPLAY,
  parameter int unsigned H_FPORCH    = VGA640_H_FPORCH,
  parameter int unsigned H_SYNCPULSE = VGA640_H_SYNCPULSE,
  parameter int unsigned H_BPORCH    = VGA640_H_BPORCH,
  parameter int unsigned V_DISPLAY   = VGA640_V_DISPLAY,
  parameter int unsigned V_FPORCH    = VGA640_V_FPORCH,
  parameter int unsigned V_SYNCPULSE = VGA640_V_SYNCPULSE,
  parameter int unsigned V_BPORCH    = VGA640_V_BPORCH,
  parameter bit          HSYNC_POL   = VGA640_HSYNC_POL,
  parameter bit          VSYNC_POL   = VGA640_VSYNC_POL,
  parameter int unsigned CW          = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          display,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FPORCH + H_SYNCPULSE + H_BPORCH;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FPORCH + V_SYNCPULSE + V_BPORCH;

  if (CW < calc_cw(H_TOTAL, V_TOTAL)) begin : g_chk_cw
    $fatal(1, "vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_active, v_active, h_sync_on, v_sync_on, h_wrap, v_wrap;

  vga_axis_counter #(
    .DISP(H_DISPLAY), .FP(H_FPORCH), .SP(H_SYNCPULSE), .BP(H_BPORCH), .CW(CW)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .adv(pix_en),
    .cnt(h_cnt), .active(h_active), .sync_on(h_sync_on), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .DISP(V_DISPLAY), .FP(V_FPORCH), .SP(V_SYNCPULSE), .BP(V_BPORCH), .CW(CW)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .adv(pix_en & h_wrap),
    .cnt(v_cnt), .active(v_active), .sync_on(v_sync_on), .wrap(v_wrap)
  );

  assign display = h_active & v_active;
  assign x       = display ? h_cnt : '0;
  assign y       = display ? v_cnt : '0;
  assign hsync   = HSYNC_POL ? h_sync_on : ~h_sync_on;
  assign vsync   = VSYNC_POL ? v_sync_on : ~v_sync_on;

  // Strobes flag the edge that lands on column 0 (and row 0); they clear on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en & h_wrap;
      frame_start <= pix_en & h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench: default 640x480 and a tiny positive-polarity geometry vs a pixel-index model.
module tb_vga_timing_gen;

  localparam int AHD = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVD = 480, AVF = 10, AVS = 2,  AVB = 33;
  localparam int AHT = AHD + AHF + AHS + AHB;
  localparam int AVT = AVD + AVF + AVS + AVB;

  localparam int BHD = 8, BHF = 2, BHS = 3, BHB = 2;
  localparam int BVD = 4, BVF = 1, BVS = 2, BVB = 1;
  localparam int BHT = BHD + BHF + BHS + BHB;
  localparam int BVT = BVD + BVF + BVS + BVB;

  logic clk = 1'b0;
  logic rst_n, pix_en;

  logic       hs_a, vs_a, disp_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, disp_b, ls_b, fs_b;
  logic [3:0] x_b, y_b;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(hs_a), .vsync(vs_a), .display(disp_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(BHD), .H_FPORCH(BHF), .H_SYNCPULSE(BHS), .H_BPORCH(BHB),
    .V_DISPLAY(BVD), .V_FPORCH(BVF), .V_SYNCPULSE(BVS), .V_BPORCH(BVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(hs_b), .vsync(vs_b), .display(disp_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  // Model: linear pixel index within the frame; h/v are derived by div/mod.
  int pos_a, pos_b;
  bit els_a, efs_a, els_b, efs_b;

  task automatic model_reset();
    pos_a = AHT * AVT - 1;
    pos_b = BHT * BVT - 1;
    els_a = 0; efs_a = 0; els_b = 0; efs_b = 0;
  endtask

  task automatic model_step(input bit en);
    if (en) begin
      pos_a = (pos_a + 1) % (AHT * AVT);
      pos_b = (pos_b + 1) % (BHT * BVT);
      els_a = (pos_a % AHT) == 0;
      efs_a = pos_a == 0;
      els_b = (pos_b % BHT) == 0;
      efs_b = pos_b == 0;
    end else begin
      els_a = 0; efs_a = 0; els_b = 0; efs_b = 0;
    end
  endtask

  task automatic check_all();
    int h, v, d, hin, vin;
    h = pos_a % AHT;  v = pos_a / AHT;
    d   = (h < AHD && v < AVD) ? 1 : 0;
    hin = (h >= AHD + AHF && h < AHD + AHF + AHS) ? 1 : 0;
    vin = (v >= AVD + AVF && v < AVD + AVF + AVS) ? 1 : 0;
    chk("a_display", int'(disp_a), d);
    chk("a_x", int'(x_a), d ? h : 0);
    chk("a_y", int'(y_a), d ? v : 0);
    chk("a_hsync", int'(hs_a), hin ? 0 : 1);
    chk("a_vsync", int'(vs_a), vin ? 0 : 1);
    chk("a_line_start", int'(ls_a), int'(els_a));
    chk("a_frame_start", int'(fs_a), int'(efs_a));
    h = pos_b % BHT;  v = pos_b / BHT;
    d   = (h < BHD && v < BVD) ? 1 : 0;
    hin = (h >= BHD + BHF && h < BHD + BHF + BHS) ? 1 : 0;
    vin = (v >= BVD + BVF && v < BVD + BVF + BVS) ? 1 : 0;
    chk("b_display", int'(disp_b), d);
    chk("b_x", int'(x_b), d ? h : 0);
    chk("b_y", int'(y_b), d ? v : 0);
    chk("b_hsync", int'(hs_b), hin ? 1 : 0);
    chk("b_vsync", int'(vs_b), vin ? 1 : 0);
    chk("b_line_start", int'(ls_b), int'(els_b));
    chk("b_frame_start", int'(fs_b), int'(efs_b));
  endtask

  initial begin
    bit force_en;
    rst_n  = 1'b0;
    pix_en = 1'b0;
    force_en = 1'b1;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (force_en)          pix_en = 1'b1;
      else if (cyc < 3000)   pix_en = 1'b1;
      else if (cyc < 6000)   pix_en = cyc[0];
      else                   pix_en = ($urandom_range(0, 3) != 0);
      force_en = 1'b0;

      @(posedge clk);
      if (rst_n) model_step(pix_en);
      else       model_reset();
      #1 check_all();

      // Occasional asynchronous reset landing between clock edges.
      if (cyc > 3000 && $urandom_range(0, 2999) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        model_reset();
        #1 check_all();
        #1 rst_n = 1'b1;
        force_en = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; replaces the separate horizontal-only sync counter.
- Produces horizontal and vertical timing from one pixel counter pair: hsync, vsync, active-video flag, pixel coordinates, line/frame start strobes.
- Sits between the pixel clock-enable source and the ToVga pixel/colour path.
- Adds over the previous generation:
  - vertical axis
  - configurable sync polarity
  - clock enable
  - async reset
  - coordinate outputs and strobes

Parameters:
H_DISPLAY, 640, active pixels per line
H_FPORCH, 16, horizontal front porch (pixels)
H_SYNCPULSE, 96, hsync pulse width (pixels)
H_BPORCH, 48, horizontal back porch (pixels)
V_DISPLAY, 480, active lines per frame
V_FPORCH, 10, vertical front porch (lines)
V_SYNCPULSE, 2, vsync pulse width (lines)
V_BPORCH, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync
CW, 10, width of counters and x/y outputs

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel clock enable; timing advances only when 1
hsync  out  1  horizontal sync, level per HSYNC_POL
vsync  out  1  vertical sync, level per VSYNC_POL
display  out  1  1 = active video region
x  out  CW  pixel column; valid when display=1, else 0
y  out  CW  line number; valid when display=1, else 0
line_start  out  1  one-clk strobe at first pixel of each line
frame_start  out  1  one-clk strobe at pixel (0,0) of each frame

Behaviour:
- Totals:
  - H_TOTAL = H_DISPLAY + H_FPORCH + H_SYNCPULSE + H_BPORCH (default 800)
  - V_TOTAL likewise (default 525)
- Counters:
  - h_cnt runs 0..H_TOTAL-1.
  - v_cnt runs 0..V_TOTAL-1.
- Region order per axis, from counter 0: display, front porch, sync, back porch.
- Reset (rst_n=0, asynchronous):
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1 (last pixel of back porch).
  - Outputs: display=0, x=0, y=0, line_start=0, frame_start=0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL (deasserted).
- Counter update, on each clk edge with pix_en=1:
  - If h_cnt==H_TOTAL-1: h_cnt=0, and v_cnt advances (wraps V_TOTAL-1 -> 0).
  - Otherwise h_cnt+1, v_cnt unchanged.
- pix_en=0: counters and all level outputs hold; strobes drop to 0.
- All outputs are registered and decoded from the next counter values, so they are aligned with the counters. No extra pipeline latency: outputs describe the pixel the counters currently hold.
- display = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
- x = h_cnt and y = v_cnt when display=1, else 0.
- hsync asserted iff H_DISPLAY+H_FPORCH <= h_cnt < H_DISPLAY+H_FPORCH+H_SYNCPULSE (default 656..751).
- vsync asserted iff V_DISPLAY+V_FPORCH <= v_cnt < V_DISPLAY+V_FPORCH+V_SYNCPULSE (default lines 490..491, whole lines).
- line_start: 1 for exactly one clk after a pix_en edge that moved h_cnt to 0 (every line, including blanking lines).
- frame_start: same rule, when h_cnt and v_cnt both become 0; coincides with a line_start.
- First pix_en after reset release: counters go to (0,0) with display=1, line_start=1, frame_start=1.
- Reset mid-frame: immediate return to the reset state above; no partial-line memory.
- Elaboration checks (fatal):
  - 2^CW must exceed both H_TOTAL-1 and V_TOTAL-1.
  - Every porch and pulse parameter must be >= 1.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 constants;
  - an 800x600 constant set;
  - a function computing the required CW from the totals.
- Sub-module vga_axis_counter, instanced twice (horizontal and vertical):
  - ports: clk, rst_n, adv, DISP/FP/SP/BP parameters;
  - outputs: cnt, active, sync_on, wrap.
- The horizontal instance's wrap drives the vertical instance's adv (ANDed with pix_en).
- Top level handles polarity, x/y gating and strobes.

Test Plan:
1. Reset then pix_en=1 constantly, defaults -> cycle 1: x=0, y=0, display=1, frame_start=1; hsync low exactly for h_cnt 656..751 each line; line_start period 800 clk.
2. Defaults, full frame -> vsync low for lines 490..491 (1600 clk); frame_start period 420000 clk; display high 640 clk per line for lines 0..479 only.
3. pix_en toggling 1,0,1,0 -> counters advance every second clk; strobes last 1 clk; hsync, display, x, y hold during pix_en=0.
4. HSYNC_POL=1, VSYNC_POL=1, small geometry (H 8/2/3/2, V 4/1/2/1) -> hsync high h_cnt 10..12, vsync high v_cnt 5..6, H_TOTAL=15, V_TOTAL=8.
5. Assert rst_n at h_cnt=300, v_cnt=200, mid-clk -> outputs go to reset values immediately; after release, next pix_en gives (0,0) with frame_start=1.
6. Wrap boundary, small geometry -> at h=14, v=7 with pix_en=1: next cycle h=0, v=0, line_start=1, frame_start=1; at h=14, v=3: next v=4, frame_start=0.
